// File: rtl/hpdcache_scratchpad_responder_if.sv
// hpdcache_scratchpad_responder_if: core-request / response bundle of the HPDcache scratchpad responder
//   req_valid_i/req_ready_o  request handshake, transfer when both high
//   req_op_i, req_addr_i, req_wdata_i, req_be_i, req_size_i, req_sid_i, req_tid_i, req_need_rsp_i  request payload
//   rsp_valid_o, rsp_rdata_o, rsp_sid_o, rsp_tid_o, rsp_error_o  single-cycle response, no backpressure
//   modport master: requester side, modport slave: responder side
interface hpdcache_scratchpad_responder_if #(
    parameter int unsigned SID_WIDTH = 3,
    parameter int unsigned TID_WIDTH = 6
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [3:0]           req_op_i;
    logic [31:0]          req_addr_i;
    logic [63:0]          req_wdata_i;
    logic [7:0]           req_be_i;
    logic [1:0]           req_size_i;
    logic [SID_WIDTH-1:0] req_sid_i;
    logic [TID_WIDTH-1:0] req_tid_i;
    logic                 req_need_rsp_i;
    logic                 rsp_valid_o;
    logic [63:0]          rsp_rdata_o;
    logic [SID_WIDTH-1:0] rsp_sid_o;
    logic [TID_WIDTH-1:0] rsp_tid_o;
    logic                 rsp_error_o;

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_be_i, req_size_i,
               req_sid_i, req_tid_i, req_need_rsp_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_sid_o, rsp_tid_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_be_i, req_size_i,
               req_sid_i, req_tid_i, req_need_rsp_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_sid_o, rsp_tid_o, rsp_error_o
    );
endinterface

// File: rtl/hpdcache_scratchpad_responder.sv
// hpdcache_scratchpad_responder: scratchpad-backed responder for HPDcache core requests (load/store/AMO/LR/SC)
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     hpdcache_scratchpad_responder_if.slave: request handshake/payload in, registered response out
//   Optional: define HPDCACHE_SCRATCHPAD_STALL_EN to insert pseudo-random ready stalls (16-bit LFSR).
module hpdcache_scratchpad_responder #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned SID_WIDTH = 3,
    parameter int unsigned TID_WIDTH = 6
) (
    input logic clk_i,
    input logic rst_ni,
    hpdcache_scratchpad_responder_if.slave bus
);
    localparam int unsigned IW = $clog2(MEM_WORDS);
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LR    = 4'd4;
    localparam logic [3:0] OP_SC    = 4'd5;
    localparam logic [3:0] OP_SWAP  = 4'd6;
    localparam logic [3:0] OP_ADD   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_MAX   = 4'd11;
    localparam logic [3:0] OP_MAXU  = 4'd12;
    localparam logic [3:0] OP_MIN   = 4'd13;

    typedef enum logic {IDLE, AMO_WRITE} state_e;

    typedef struct packed {
        logic                 v;
        logic [63:0]          d;
        logic [SID_WIDTH-1:0] s;
        logic [TID_WIDTH-1:0] t;
        logic                 e;
    } rsp_t;

    state_e               r_state;
    logic                 r_ready;
    logic [63:0]          r_mem [MEM_WORDS];
    rsp_t                 r_pipe [LATENCY];
    logic                 r_res_v;
    logic [IW-1:0]        r_res_idx;
    logic [3:0]           r_op;
    logic                 r_dw;
    logic                 r_hi;
    logic [IW-1:0]        r_idx;
    logic [63:0]          r_old;
    logic [63:0]          r_opnd;
    logic [SID_WIDTH-1:0] r_sid;
    logic [TID_WIDTH-1:0] r_tid;

    logic                 w_acc;
    logic [IW-1:0]        w_idx;
    logic                 w_amo;
    logic                 w_err;
    logic                 w_go_amo;
    logic                 w_nxt_idle;
    logic                 w_stall;
    logic [63:0]          w_rword;
    logic [31:0]          w_half;
    logic [63:0]          w_a;
    logic [63:0]          w_b;
    logic [63:0]          w_res;
    logic [63:0]          w_new;
    logic                 w_sc_ok;
    logic                 w_amo_wr;
    rsp_t                 w_rsp_in;
    logic                 w_unused;

    assign w_unused   = &{1'b0, bus.req_addr_i[1:0]};
    assign w_acc      = bus.req_valid_i & r_ready;
    assign w_idx      = bus.req_addr_i[3 +: IW];
    assign w_rword    = r_mem[w_idx];
    // LR..MINU form one contiguous opcode range; AMOs need a word or dword size
    assign w_amo      = bus.req_op_i >= OP_LR && bus.req_op_i <= 4'd14;
    assign w_err      = ((bus.req_addr_i >> (3 + IW)) != 32'd0)
                      | ~(bus.req_op_i == OP_LOAD | bus.req_op_i == OP_STORE | (w_amo & bus.req_size_i[1]));
    assign w_go_amo   = w_acc & w_amo & ~w_err;
    assign w_nxt_idle = r_state == AMO_WRITE || !w_go_amo;

    // Word AMOs work on sign-extended halves; sign extension preserves unsigned order, so the
    // 64-bit comparators serve both operand widths.
    assign w_half   = r_hi ? r_old[63:32] : r_old[31:0];
    assign w_a      = r_dw ? r_old : {{32{w_half[31]}}, w_half};
    assign w_b      = r_dw ? r_opnd : {{32{r_opnd[31]}}, r_opnd[31:0]};
    assign w_sc_ok  = r_res_v && r_res_idx == r_idx;
    assign w_res    = (r_op == OP_SWAP || r_op == OP_SC) ? w_b :
                      r_op == OP_ADD  ? w_a + w_b :
                      r_op == OP_AND  ? w_a & w_b :
                      r_op == OP_OR   ? w_a | w_b :
                      r_op == OP_XOR  ? w_a ^ w_b :
                      r_op == OP_MAX  ? ($signed(w_a) > $signed(w_b) ? w_a : w_b) :
                      r_op == OP_MAXU ? (w_a > w_b ? w_a : w_b) :
                      r_op == OP_MIN  ? ($signed(w_a) < $signed(w_b) ? w_a : w_b) :
                                        (w_a < w_b ? w_a : w_b);
    assign w_new    = r_dw ? w_res : r_hi ? {w_res[31:0], r_old[31:0]} : {r_old[63:32], w_res[31:0]};
    assign w_amo_wr = r_op >= OP_SWAP || (r_op == OP_SC && w_sc_ok);

    // AMO responses enter the pipe during the stall cycle, when no new request can be accepted
    always_comb begin
        w_rsp_in = '0;
        if (r_state == AMO_WRITE)
            w_rsp_in = '{1'b1, r_op == OP_SC ? {63'd0, ~w_sc_ok} : w_a, r_sid, r_tid, 1'b0};
        else if (w_acc && (w_err || bus.req_op_i == OP_LOAD || (bus.req_op_i == OP_STORE && bus.req_need_rsp_i)))
            w_rsp_in = '{1'b1, (w_err || bus.req_op_i != OP_LOAD) ? 64'd0 : w_rword,
                         bus.req_sid_i, bus.req_tid_i, w_err};
    end

`ifdef HPDCACHE_SCRATCHPAD_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // ready is registered, so it is derived from the LFSR value that will be current next cycle
    assign w_stall    = &w_lfsr_nxt[1:0];
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_lfsr <= 16'hACE1;
        else         r_lfsr <= w_lfsr_nxt;
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_res_v   <= 1'b0;
            r_res_idx <= '0;
            r_op      <= '0;
            r_dw      <= 1'b0;
            r_hi      <= 1'b0;
            r_idx     <= '0;
            r_old     <= '0;
            r_opnd    <= '0;
            r_sid     <= '0;
            r_tid     <= '0;
            for (int i = 0; i < int'(MEM_WORDS); i++) r_mem[i] <= '0;
            for (int i = 0; i < int'(LATENCY); i++) r_pipe[i] <= '0;
        end else begin
            r_ready   <= w_nxt_idle & ~w_stall;
            r_pipe[0] <= w_rsp_in;
            for (int i = 1; i < int'(LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
            if (r_state == IDLE) begin
                if (w_go_amo) begin
                    r_state <= AMO_WRITE;
                    r_op    <= bus.req_op_i;
                    r_dw    <= bus.req_size_i[0];
                    r_hi    <= bus.req_addr_i[2];
                    r_idx   <= w_idx;
                    r_old   <= w_rword;
                    r_opnd  <= bus.req_wdata_i;
                    r_sid   <= bus.req_sid_i;
                    r_tid   <= bus.req_tid_i;
                end
                if (w_acc && bus.req_op_i == OP_STORE && !w_err) begin
                    for (int b = 0; b < 8; b++)
                        if (bus.req_be_i[b]) r_mem[w_idx][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
                    if (w_idx == r_res_idx) r_res_v <= 1'b0;
                end
            end else begin
                r_state <= IDLE;
                if (w_amo_wr) r_mem[r_idx] <= w_new;
                if (r_op == OP_LR) begin
                    r_res_v   <= 1'b1;
                    r_res_idx <= r_idx;
                end else if (r_op == OP_SC || (w_amo_wr && r_idx == r_res_idx)) begin
                    r_res_v <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready_o = r_ready;
    assign bus.rsp_valid_o = r_pipe[LATENCY-1].v;
    assign bus.rsp_rdata_o = r_pipe[LATENCY-1].d;
    assign bus.rsp_sid_o   = r_pipe[LATENCY-1].s;
    assign bus.rsp_tid_o   = r_pipe[LATENCY-1].t;
    assign bus.rsp_error_o = r_pipe[LATENCY-1].e;
endmodule

// File: tb/tb_hpdcache_scratchpad_responder.sv
// tb_hpdcache_scratchpad_responder: scoreboard bench for the scratchpad responder
module tb_hpdcache_scratchpad_responder;
    localparam int LAT = 2;
    localparam int SW  = 3;
    localparam int TW  = 6;
    localparam int MW  = 256;
`ifdef HPDCACHE_SCRATCHPAD_STALL_EN
    localparam int NR = 1000;
`else
    localparam int NR = 300;
`endif

    typedef struct {
        logic [63:0]   d;
        logic [SW-1:0] s;
        logic [TW-1:0] t;
        logic          e;
        int            at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q[$];
    logic [63:0] mem [MW];
    logic        res_v;
    int          res_i;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hpdcache_scratchpad_responder_if #(.SID_WIDTH(SW), .TID_WIDTH(TW)) bus();

    hpdcache_scratchpad_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .SID_WIDTH(SW), .TID_WIDTH(TW)) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] alu64(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        case (op)
            4'd6:    return b;
            4'd7:    return a + b;
            4'd8:    return a & b;
            4'd9:    return a | b;
            4'd10:   return a ^ b;
            4'd11:   return $signed(a) > $signed(b) ? a : b;
            4'd12:   return a > b ? a : b;
            4'd13:   return $signed(a) < $signed(b) ? a : b;
            default: return a < b ? a : b;
        endcase
    endfunction

    function automatic logic [31:0] alu32(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd6:    return b;
            4'd7:    return a + b;
            4'd8:    return a & b;
            4'd9:    return a | b;
            4'd10:   return a ^ b;
            4'd11:   return $signed(a) > $signed(b) ? a : b;
            4'd12:   return a > b ? a : b;
            4'd13:   return $signed(a) < $signed(b) ? a : b;
            default: return a < b ? a : b;
        endcase
    endfunction

    // reference model, applied in acceptance order
    task automatic model(logic [3:0] op, logic [31:0] addr, logic [63:0] wd, logic [7:0] be,
                         logic [1:0] sz, logic [SW-1:0] sid, logic [TW-1:0] tid, logic nr, int c);
        int          idx;
        logic        wr;
        logic [63:0] old;
        logic [63:0] rsp;
        logic [31:0] o32;
        logic [31:0] n32;
        idx = int'(addr[10:3]);
        if (addr >= MW * 8 || !(op == 0 || op == 1 || (op >= 4 && op <= 14 && sz >= 2))) begin
            q.push_back('{64'd0, sid, tid, 1'b1, c + LAT});
            return;
        end
        if (op == 0) begin
            q.push_back('{mem[idx], sid, tid, 1'b0, c + LAT});
        end else if (op == 1) begin
            for (int b = 0; b < 8; b++) if (be[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
            if (res_v && res_i == idx) res_v = 1'b0;
            if (nr) q.push_back('{64'd0, sid, tid, 1'b0, c + LAT});
        end else begin
            old = mem[idx];
            o32 = addr[2] ? old[63:32] : old[31:0];
            rsp = sz == 3 ? old : {{32{o32[31]}}, o32};
            if (op == 4) begin
                res_v = 1'b1;
                res_i = idx;
            end else begin
                wr = op != 5 || (res_v && res_i == idx);
                if (op == 5) rsp = {63'd0, ~wr};
                if (wr && sz == 3) mem[idx] = op == 5 ? wd : alu64(op, old, wd);
                if (wr && sz == 2) begin
                    n32 = op == 5 ? wd[31:0] : alu32(op, o32, wd[31:0]);
                    if (addr[2]) mem[idx][63:32] = n32;
                    else         mem[idx][31:0]  = n32;
                end
                if (op == 5 || (res_v && res_i == idx)) res_v = 1'b0;
            end
            q.push_back('{rsp, sid, tid, 1'b0, c + 1 + LAT});
        end
    endtask

    task automatic send(logic [3:0] op, logic [31:0] addr, logic [63:0] wd, logic [7:0] be,
                        logic [1:0] sz, logic [SW-1:0] sid, logic [TW-1:0] tid, logic nr);
        int w = 0;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = op;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        bus.req_be_i       = be;
        bus.req_size_i     = sz;
        bus.req_sid_i      = sid;
        bus.req_tid_i      = tid;
        bus.req_need_rsp_i = nr;
        while (!bus.req_ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready_o) begin
            check("ready_timeout", 64'(bus.req_ready_o), 64'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        model(op, addr, wd, be, sz, sid, tid, nr, cyc);
    endtask

    task automatic idle(int n);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic reset_model();
        q.delete();
        res_v = 1'b0;
        res_i = 0;
        for (int i = 0; i < MW; i++) mem[i] = '0;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_ready"}, 64'(bus.req_ready_o), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, "_rdata"}, bus.rsp_rdata_o, 64'd0);
        check({tag, "_sid_tid_err"}, 64'({bus.rsp_sid_o, bus.rsp_tid_o, bus.rsp_error_o}), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid_o) begin
            if (q.size() == 0) begin
                check("unexpected_rsp_queue", 64'(q.size()), 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_rdata", bus.rsp_rdata_o, e.d);
                check("rsp_sid", 64'(bus.rsp_sid_o), 64'(e.s));
                check("rsp_tid", 64'(bus.rsp_tid_o), 64'(e.t));
                check("rsp_error", 64'(bus.rsp_error_o), 64'(e.e));
                check("rsp_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_op_i       = '0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.req_be_i       = '0;
        bus.req_size_i     = '0;
        bus.req_sid_i      = '0;
        bus.req_tid_i      = '0;
        bus.req_need_rsp_i = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        send(4'd1, 32'h10, 64'h1122334455667788, 8'hFF, 2'd3, 3'd0, 6'd9, 1'b0);
        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd2, 6'd5, 1'b1);
        idle(4);

        send(4'd1, 32'h10, 64'h7FFFFFFF_00000000, 8'hFF, 2'd3, 3'd1, 6'd10, 1'b1);
        send(4'd7, 32'h14, 64'h00000001, 8'h00, 2'd2, 3'd3, 6'd11, 1'b1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("amo_stall_ready", 64'(bus.req_ready_o), 64'd0);
`ifndef HPDCACHE_SCRATCHPAD_STALL_EN
        @(negedge clk);
        check("amo_ready_back", 64'(bus.req_ready_o), 64'd1);
`endif
        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd3, 6'd12, 1'b1);
        idle(5);

        send(4'd4, 32'h20, 64'd0, 8'h00, 2'd3, 3'd0, 6'd13, 1'b1);
        send(4'd5, 32'h20, 64'hAB, 8'h00, 2'd3, 3'd0, 6'd14, 1'b1);
        send(4'd0, 32'h20, 64'd0, 8'h00, 2'd3, 3'd0, 6'd15, 1'b1);
        send(4'd4, 32'h20, 64'd0, 8'h00, 2'd3, 3'd0, 6'd16, 1'b1);
        send(4'd1, 32'h20, 64'h55, 8'hFF, 2'd3, 3'd4, 6'd17, 1'b0);
        send(4'd5, 32'h20, 64'hCD, 8'h00, 2'd3, 3'd0, 6'd18, 1'b1);
        send(4'd0, 32'h20, 64'd0, 8'h00, 2'd3, 3'd0, 6'd19, 1'b1);
        idle(5);

        send(4'd0, 32'h800, 64'd0, 8'h00, 2'd3, 3'd1, 6'd20, 1'b1);
        send(4'd3, 32'h18, 64'hFFFF, 8'hFF, 2'd3, 3'd1, 6'd21, 1'b1);
        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd1, 6'd22, 1'b1);
        send(4'd0, 32'h18, 64'd0, 8'h00, 2'd3, 3'd1, 6'd23, 1'b1);
        idle(5);

        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd5, 6'd1, 1'b1);
        send(4'd0, 32'h20, 64'd0, 8'h00, 2'd3, 3'd5, 6'd2, 1'b1);
        send(4'd0, 32'h18, 64'd0, 8'h00, 2'd3, 3'd5, 6'd3, 1'b1);
        idle(5);

        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd6, 6'd30, 1'b1);
        send(4'd0, 32'h20, 64'd0, 8'h00, 2'd3, 3'd6, 6'd31, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid_i = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(4'd0, 32'h10, 64'd0, 8'h00, 2'd3, 3'd7, 6'd32, 1'b1);
        idle(5);

        for (int k = 0; k < NR; k++) begin
            int          r;
            logic [3:0]  op;
            logic [31:0] addr;
            r    = int'($urandom_range(0, 99));
            op   = r < 35 ? 4'd0 : r < 65 ? 4'd1 : r < 67 ? 4'd3 : 4'($urandom_range(4, 14));
            addr = (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) addr = addr | 32'h800;
            send(op, addr, {$urandom, $urandom}, 8'($urandom), op >= 4 ? 2'($urandom_range(1, 3)) : 2'd3,
                 3'($urandom), 6'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(LAT + 5);
        check("drain_queue", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hpdcache_scratchpad_responder.md
Name: hpdcache_scratchpad_responder

Overview:
- Responder end of the HPDcache core-request interface: accepts the requests a core-side adapter issues (load, store, AMO incl. LR/SC) and returns responses carrying the originating SID/TID.
- Backed by a local 64-bit-word scratchpad; fixed, parameterised response latency; LR/SC reservation tracking.
- Used as a dcache-less memory endpoint for adapter-level integration and standalone verification of request/response paths.

Parameters:
- MEM_WORDS, 256, number of 64-bit words; power of two, >=2.
- LATENCY, 2, cycles from request acceptance to response for load/store; legal 1..4.
- SID_WIDTH, 3, source ID width.
- TID_WIDTH, 6, transaction ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready; transfer when valid&ready.
- req_op_i  in  4  0 LOAD, 1 STORE, 4 LR, 5 SC, 6 SWAP, 7 ADD, 8 AND, 9 OR, 10 XOR, 11 MAX, 12 MAXU, 13 MIN, 14 MINU; others illegal.
- req_addr_i  in  32  physical byte address.
- req_wdata_i  in  64  write/operand data.
- req_be_i  in  8  byte enables (store).
- req_size_i  in  2  log2 bytes; AMO legal 2 (word) or 3 (dword).
- req_sid_i  in  SID_WIDTH  source ID.
- req_tid_i  in  TID_WIDTH  transaction ID.
- req_need_rsp_i  in  1  response requested (loads/AMOs always respond).
- rsp_valid_o  out  1  response valid, one cycle, no backpressure.
- rsp_rdata_o  out  64  response data.
- rsp_sid_o  out  SID_WIDTH  echoed SID.
- rsp_tid_o  out  TID_WIDTH  echoed TID.
- rsp_error_o  out  1  out-of-range address or illegal op.

Behaviour:
- Reset (async, rst_ni low): req_ready_o=0, rsp_valid_o=0, rsp_rdata_o/sid/tid/error=0, all memory words=0, reservation cleared, pipeline flushed, FSM=IDLE. Reset mid-operation drops every in-flight response and any pending AMO write.
- Word index = addr[3+:log2(MEM_WORDS)]; addr[2:0] ignored except addr[2] for 32-bit AMOs. Address >= MEM_WORDS*8 -> no memory access, error response.
- Illegal op -> no memory access, error response with rdata=0.
- FSM IDLE: req_ready_o=1. LOAD/STORE accepted at T: read word (LOAD) or write bytes under req_be_i at T's edge (STORE); response enters LATENCY-stage shift pipeline and appears at T+LATENCY.
- STORE with need_rsp=0: no response. STORE with need_rsp=1: rdata=0.
- AMO accepted at T in IDLE -> AMO_WRITE for cycle T+1 with req_ready_o=0. The old word is captured at T; the new value is computed and written at the T+1 edge. Response (old value) appears at T+1+LATENCY; FSM returns to IDLE.
- Dword AMO: full 64 bits. Word AMO: operate on the half selected by addr[2]. Old value is returned sign-extended to 64 bits; the other half is unchanged. MAX/MIN are signed and MAXU/MINU unsigned at operand width. ADD wraps modulo operand width.
- LR: returns word, sets reservation {valid, word index}, no write.
- SC: if reservation valid and index matches, write and rdata=0; else no write, rdata=1. Reservation cleared after any SC.
- Any STORE or AMO write (incl. other SID) to the reserved word clears the reservation; LR overwrites any existing reservation.
- Ordering: responses leave in acceptance order; the AMO stall cycle guarantees no pipeline collision. A load accepted the cycle after a store/AMO write to the same word observes the new data.
- Only one rsp_valid_o per cycle; outputs are registered.

Optional Feature:
- HPDCACHE_SCRATCHPAD_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advances every cycle) forces req_ready_o=0 when its two LSBs are both 1 (~25% of IDLE cycles). A request stalled this way must be held stable by the requester.
- Not defined: req_ready_o is low only during reset and AMO_WRITE.

Test Plan:
- STORE addr 0x10, wdata 0x1122334455667788, be 0xFF, need_rsp=0; then LOAD addr 0x10, tid 5, sid 2 -> one response 2 cycles after load accept: rdata 0x1122334455667788, tid 5, sid 2, no response for the store.
- Word AMO_ADD addr 0x14, operand 0x00000001, memory 0x7FFFFFFF_00000000 -> req_ready_o low the next cycle; rsp rdata 0x000000007FFFFFFF at T+3; memory becomes 0x80000000_00000000.
- LR addr 0x20 then SC addr 0x20 wdata 0xAB -> SC rdata 0, word = 0xAB. LR, then STORE to 0x20, then SC -> SC rdata 1, word unchanged by SC.
- LOAD addr 0x800 (MEM_WORDS=256) -> rsp_error_o=1, rdata 0; memory untouched. Op 3 -> rsp_error_o=1.
- Back-to-back LOADs tids 1,2,3 accepted on consecutive cycles -> responses on consecutive cycles in order 1,2,3. Assert reset with two responses in flight -> no response emerges after reset release.
- With HPDCACHE_SCRATCHPAD_STALL_EN: 1000 random loads/stores checked against a reference memory model -> zero data mismatches, every load answered exactly once, and no acceptance on a cycle when req_ready_o=0.
